uart_tx_engine: RTL

UART transmitter for the system's serial link, the transmit-side counterpart of the UART receive path. It accepts one parallel byte per handshake and serialises it LSB-first as a start bit, 8 data bits, an optional even/odd parity bit and a stop bit. Each bit is held for a programmable number of `clk` cycles. It sits between the system's TX data source (register file / FIFO read side) and the `TX_OUT` pad.

---
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_tx_engine.sv | 132 +++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle between the TX data source and uart_tx_engine.
interface uart_tx_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      TX_OUT;
  logic                      busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmitter: start, LSB-first data, optional parity, stop; P clk cycles per bit.
// Define UART_TX_TWO_STOP_EN to send two stop bits (adds state STOP2).
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (low)
// DATA   | data bits, shift_reg[0] on the line
// PARITY | parity bit of the latched byte
// STOP   | stop bit (high)
// STOP2  | second stop bit (two-stop build only)
module uart_tx_engine #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic     clk,
  input  logic     RST,
  uart_tx_if.slave tx
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
    STOP2  = 3'd5,
`endif
    STOP   = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  state_t                    state, state_nxt;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] p_last;
  logic [2:0]                bit_cnt;
  logic [DATA_WIDTH-1:0]     shift_reg;
  logic                      par_en_q;
  logic                      par_bit_q;
  logic                      accept;
  logic                      bit_done;
  logic                      tx_nxt, busy_nxt;
  logic                      tx_q, busy_q;

  // Outputs lag the state by one cycle, so the FSM is back in IDLE one cycle
  // before busy drops; accepting on the state gives the 1-cycle inter-frame gap.
  assign accept   = (state == IDLE) && tx.Data_Valid;
  assign bit_done = (state != IDLE) && (edge_cnt == p_last);

  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = START;
      START:  if (bit_done) state_nxt = DATA;
      DATA: begin
        if (bit_done && (bit_cnt == LAST_BIT)) begin
          state_nxt = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: if (bit_done) state_nxt = STOP;
`ifdef UART_TX_TWO_STOP_EN
      STOP:   if (bit_done) state_nxt = STOP2;
      STOP2:  if (bit_done) state_nxt = IDLE;
`else
      STOP:   if (bit_done) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state != IDLE);
    case (state)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_reg[0];
      PARITY:  tx_nxt = par_bit_q;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      tx_q   <= tx_nxt;
      busy_q <= busy_nxt;
    end
  end

  // Frame datapath: everything a frame needs is captured at acceptance.
  always_ff @(posedge clk) begin
    if (RST) begin
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      p_last    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (accept) begin
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= tx.P_DATA;
      p_last    <= (tx.Prescale == '0) ? '0 : tx.Prescale - PRESCALE_WIDTH'(1);
      par_en_q  <= tx.PAR_EN;
      par_bit_q <= tx.PAR_TYP ? ~^tx.P_DATA : ^tx.P_DATA;
    end else if (state != IDLE) begin
      if (bit_done) begin
        edge_cnt <= '0;
        if (state == DATA) begin
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= bit_cnt + 3'd1;
        end
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
      end
    end
  end

  assign tx.TX_OUT = tx_q;
  assign tx.busy   = busy_q;

endmodule
